// File: rtl/svo_stream_monitor.sv
// svo_stream_monitor
// Passive observer for a valid/ready pixel stream. It checks frame geometry
// against start-of-frame, counts frames and error events, and signs each
// completed frame with CRC-16/CCITT-FALSE. It never drives the stream.
//
// Handshake: a pixel is transferred (a "beat") on every rising clk edge where
// mon_tvalid and mon_tready are both high. Cycles without a beat leave all
// state untouched. The monitor follows the stream at full rate and has no
// backpressure path of its own.
module svo_stream_monitor #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BITS     = 24
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            mon_tvalid,
    input  logic            mon_tready,
    input  logic [BITS-1:0] mon_tdata,
    input  logic            mon_tuser,
    input  logic            clear,
    output logic            locked,
    output logic            frame_done,
    output logic [15:0]     frame_count,
    output logic [15:0]     frame_crc,
    output logic            err_short,
    output logic            err_long,
    output logic [7:0]      err_count,
    output logic [11:0]     x_pos,
    output logic [11:0]     y_pos,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        FRAME    = 2'd1,
        SOF_WAIT = 2'd2
    } state_t;

    localparam logic [11:0] X_LAST     = 12'(H_ACTIVE - 1);
    localparam logic [11:0] Y_LAST     = 12'(V_ACTIVE - 1);
    localparam bit          ONE_PIXEL  = (H_ACTIVE * V_ACTIVE == 1);
    // Position following pixel 0: a one-column frame moves straight to line 1.
    localparam logic [11:0] X_AFTER_SOF = (H_ACTIVE == 1) ? 12'd0 : 12'd1;
    localparam logic [11:0] Y_AFTER_SOF = (H_ACTIVE == 1) ? 12'd1 : 12'd0;

    // One CRC-16/CCITT-FALSE step over the whole data word, MSB first.
    function automatic logic [15:0] crc_update(input logic [15:0]     crc_in,
                                               input logic [BITS-1:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = BITS - 1; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0};
            if (fb) begin
                c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic [15:0] crc_q, crc_d;
    logic [15:0] frame_crc_q, frame_crc_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        frame_done_q, frame_done_d;
    logic        locked_q, locked_d;
    logic        err_short_q, err_short_d;
    logic        err_long_q, err_long_d;
    logic [7:0]  err_count_q, err_count_d;

    logic        beat;
    logic [15:0] crc_start;
    logic [15:0] crc_next;

    assign beat      = mon_tvalid & mon_tready;
    assign crc_start = crc_update(16'hFFFF, mon_tdata);
    assign crc_next  = crc_update(crc_q, mon_tdata);

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= HUNT;
            x_q           <= '0;
            y_q           <= '0;
            crc_q         <= '0;
            frame_crc_q   <= '0;
            frame_count_q <= '0;
            frame_done_q  <= 1'b0;
            locked_q      <= 1'b0;
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            crc_q         <= crc_d;
            frame_crc_q   <= frame_crc_d;
            frame_count_q <= frame_count_d;
            frame_done_q  <= frame_done_d;
            locked_q      <= locked_d;
            err_short_q   <= err_short_d;
            err_long_q    <= err_long_d;
            err_count_q   <= err_count_d;
        end
    end

    // Next-state logic: frame tracking, error detection and frame completion.
    always_comb begin
        logic        start_frame;
        logic        complete;
        logic        count_error;
        logic [15:0] done_crc;

        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        crc_d         = crc_q;
        frame_crc_d   = frame_crc_q;
        frame_count_d = frame_count_q;
        frame_done_d  = 1'b0;
        locked_d      = locked_q;
        err_short_d   = err_short_q;
        err_long_d    = err_long_q;
        err_count_d   = err_count_q;
        start_frame   = 1'b0;
        complete      = 1'b0;
        count_error   = 1'b0;
        done_crc      = crc_next;

        if (clear) begin
            // Clear wins over a coincident beat, which is dropped.
            state_d       = HUNT;
            x_d           = '0;
            y_d           = '0;
            crc_d         = '0;
            frame_crc_d   = '0;
            frame_count_d = '0;
            locked_d      = 1'b0;
            err_short_d   = 1'b0;
            err_long_d    = 1'b0;
            err_count_d   = '0;
        end else if (beat) begin
            case (state_q)
                HUNT: begin
                    // Pixels before the first SOF are silently skipped.
                    if (mon_tuser) begin
                        start_frame = 1'b1;
                    end
                end
                FRAME: begin
                    if (mon_tuser) begin
                        // Premature SOF: report, then resync on it.
                        err_short_d = 1'b1;
                        locked_d    = 1'b0;
                        count_error = 1'b1;
                        start_frame = 1'b1;
                    end else if (x_q == X_LAST && y_q == Y_LAST) begin
                        complete = 1'b1;
                        done_crc = crc_next;
                    end else begin
                        crc_d = crc_next;
                        if (x_q == X_LAST) begin
                            x_d = '0;
                            y_d = y_q + 12'd1;
                        end else begin
                            x_d = x_q + 12'd1;
                        end
                    end
                end
                SOF_WAIT: begin
                    if (mon_tuser) begin
                        start_frame = 1'b1;
                    end else begin
                        // Extra pixel past the frame end: drop it and rehunt.
                        err_long_d  = 1'b1;
                        locked_d    = 1'b0;
                        count_error = 1'b1;
                        state_d     = HUNT;
                        x_d         = '0;
                        y_d         = '0;
                    end
                end
                default: begin
                    state_d = HUNT;
                    x_d     = '0;
                    y_d     = '0;
                end
            endcase

            if (start_frame) begin
                if (ONE_PIXEL) begin
                    complete = 1'b1;
                    done_crc = crc_start;
                end else begin
                    crc_d   = crc_start;
                    x_d     = X_AFTER_SOF;
                    y_d     = Y_AFTER_SOF;
                    state_d = FRAME;
                end
            end

            if (complete) begin
                crc_d         = done_crc;
                frame_crc_d   = done_crc;
                frame_count_d = frame_count_q + 16'd1;
                frame_done_d  = 1'b1;
                locked_d      = 1'b1;
                x_d           = '0;
                y_d           = '0;
                state_d       = SOF_WAIT;
            end

            if (count_error && err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    assign locked      = locked_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign frame_crc   = frame_crc_q;
    assign err_short   = err_short_q;
    assign err_long    = err_long_q;
    assign err_count   = err_count_q;
    assign x_pos       = x_q;
    assign y_pos       = y_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/svo_stream_monitor.md
# svo_stream_monitor

Passive, synthesizable checker for an SVO video pixel stream: taps a valid/ready pixel interface, verifies that every frame carries exactly H_ACTIVE×V_ACTIVE pixels delimited by start-of-frame (tuser), counts frames and errors, and computes a CRC-16 signature per frame. It sits beside any stream in the system (test card, pong, encoder input) and replaces cycle-counting in simulation with self-checking status usable both on hardware and in benches.

## Interface
- H_ACTIVE, 640, active pixels per line (1..4095)
- V_ACTIVE, 480, active lines per frame (1..4095)
- BITS, 24, tdata width (1..64)
- clk  in  1  pixel clock
- resetn  in  1  asynchronous, active-low reset
- mon_tvalid  in  1  tapped tvalid
- mon_tready  in  1  tapped tready
- mon_tdata  in  BITS  tapped pixel data
- mon_tuser  in  1  tapped start-of-frame flag
- clear  in  1  synchronous clear of counters, errors, state
- locked  out  1  last frame completed cleanly, stream in sync
- frame_done  out  1  one-cycle pulse per completed frame
- frame_count  out  16  completed frames, wraps
- frame_crc  out  16  CRC of last completed frame
- err_short  out  1  sticky: SOF arrived before frame complete
- err_long  out  1  sticky: non-SOF pixel after frame complete
- err_count  out  8  error events, saturates at 255
- x_pos  out  12  next expected pixel column
- y_pos  out  12  next expected line

## Operation
- Beat = mon_tvalid & mon_tready; non-beat cycles change nothing. Block never drives the stream.
- States: HUNT, FRAME, SOF_WAIT. Reset/clear → HUNT.
- HUNT: beats with tuser=0 ignored, no error. Beat with tuser=1 starts a frame: crc=update(16'hFFFF, data), x=1, y=0 → FRAME.
- FRAME: beat with tuser=0 updates CRC, advances x; x wraps at H_ACTIVE to 0 with y+1.
- Last pixel (x=H_ACTIVE-1, y=V_ACTIVE-1, tuser=0): frame_crc←final crc, frame_count+1, frame_done pulse, locked=1, x=y=0 → SOF_WAIT.
- FRAME beat with tuser=1: err_short=1, err_count+1, locked=0; beat becomes pixel 0 of a new frame (CRC restarted, x=1, y=0), stay FRAME.
- SOF_WAIT beat with tuser=1: start frame as in HUNT → FRAME. Beat with tuser=0: err_long=1, err_count+1, locked=0, beat discarded → HUNT.
- H_ACTIVE×V_ACTIVE=1: every SOF beat completes a frame immediately (→ SOF_WAIT, frame_done).
- CRC: CRC-16/CCITT-FALSE (poly 0x1021, init 0xFFFF, no reflection, no xorout), mon_tdata shifted MSB-first, all BITS bits per beat in one cycle.
- clear has priority over any same-cycle beat (beat ignored); clears everything resetn clears.
- err_count saturates at 255; sticky flags only cleared by resetn/clear.

## Timing
- All outputs registered; reset value of every output 0; state HUNT.
- Effects of a beat visible the cycle after the clk edge that samples it; frame_done high exactly one cycle.
- frame_crc/frame_count update on the same edge as frame_done rises.
- Back-to-back beats at full rate, no stall or bubble requirement; monitor never misses a beat.
- resetn assertion mid-frame: immediate asynchronous return to reset values; next frame requires fresh SOF.

## Test plan
- H_ACTIVE=3, V_ACTIVE=3, BITS=8: two frames of bytes "123456789", SOF on first → two frame_done pulses, frame_count=2, frame_crc=16'h29B1, locked=1, err_count=0.
- After reset, 5 beats tuser=0 then a clean frame → first 5 ignored, no errors, frame_count=1.
- Clean frame, then SOF + 3 pixels, then SOF + 8 pixels → err_short=1, err_count=1, locked=0 after second SOF, frame_count=2, locked=1 at end.
- Clean frame followed by one tuser=0 beat, then clean frame → err_long=1, err_count=1, locked=0, then frame_count=2, locked=1.
- Mid-frame tvalid=1 with tready=0 for 10 cycles, and tvalid=0 gaps → x_pos/y_pos frozen, frame completes after exactly 9 beats with CRC 16'h29B1.
- 300 premature SOFs → err_count=255; clear asserted concurrently with a beat → all outputs 0, state HUNT, beat not counted.
